// File: rtl/jtdsp16_pkg.sv
// Shared definitions for the jtdsp16 program RAM: default geometry and download FSM states.
package jtdsp16_pkg;

    localparam int unsigned PRAM_AW = 12;
    localparam int unsigned PRAM_DW = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RUN   = 2'd3
    } dl_state_e;

endpackage

// File: rtl/jtdsp16_pram_mem.sv
// Single-clock program RAM: one write port, one registered read port, both cen-gated.
module jtdsp16_pram_mem #(
    parameter int unsigned AW = 12,
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          rd_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // Storage array has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (cen_i && we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (cen_i && rd_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/jtdsp16_pram.sv
// Program download receiver: fills the program RAM, sequences core reset and serves fetches.
module jtdsp16_pram
    import jtdsp16_pkg::*;
#(
    parameter int unsigned AW    = PRAM_AW,
    parameter int unsigned DW    = PRAM_DW,
    parameter int unsigned DRAIN = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic [AW-1:0] prog_addr,
    input  logic [DW-1:0] prog_data,
    input  logic          prog_we,
    input  logic [AW-1:0] fetch_addr,
    input  logic          fetch_rd,
    output logic [DW-1:0] fetch_data,
    output logic          fetch_ok,
    output logic          cpu_rst,
    output logic          dl_busy,
    output logic          dl_done,
    output logic [AW:0]   dl_cnt,
    output logic [DW-1:0] dl_sum
);

    localparam int unsigned CW  = AW + 1;
    localparam int unsigned DCW = $clog2(DRAIN + 1);
    localparam logic [CW-1:0] CNT_MAX = {1'b1, {AW{1'b0}}};

    dl_state_e      state_q;
    logic [DCW-1:0] drain_q;
    logic [CW-1:0]  cnt_q;
    logic [DW-1:0]  sum_q;
    logic           cpu_rst_q;
    logic           busy_q;
    logic           done_q;
    logic           fetch_ok_q;

    logic [CW-1:0]  cnt_d;
    logic [DW-1:0]  sum_d;
    logic           rd_c;

    // Accumulated values when the current word continues an ongoing download.
    assign cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    assign sum_d = sum_q + prog_data;
    assign rd_c  = fetch_rd && (state_q == ST_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            drain_q    <= '0;
            cnt_q      <= '0;
            sum_q      <= '0;
            cpu_rst_q  <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fetch_ok_q <= 1'b0;
        end else begin
            fetch_ok_q <= cen && rd_c;
            if (cen) begin
                case (state_q)
                    ST_IDLE, ST_RUN: begin
                        // A new download restarts count and checksum from this word.
                        if (prog_we) begin
                            state_q   <= ST_LOAD;
                            cnt_q     <= CW'(1);
                            sum_q     <= prog_data;
                            cpu_rst_q <= 1'b1;
                            busy_q    <= 1'b1;
                            done_q    <= 1'b0;
                        end
                    end
                    ST_LOAD: begin
                        if (prog_we) begin
                            cnt_q <= cnt_d;
                            sum_q <= sum_d;
                        end else begin
                            state_q <= ST_DRAIN;
                            drain_q <= DCW'(DRAIN);
                        end
                    end
                    ST_DRAIN: begin
                        if (prog_we) begin
                            state_q <= ST_LOAD;
                            cnt_q   <= cnt_d;
                            sum_q   <= sum_d;
                        end else if (drain_q <= DCW'(1)) begin
                            state_q   <= ST_RUN;
                            drain_q   <= '0;
                            cpu_rst_q <= 1'b0;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                        end else begin
                            drain_q <= drain_q - DCW'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    jtdsp16_pram_mem #(
        .AW (AW),
        .DW (DW)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .cen_i   (cen),
        .we_i    (prog_we),
        .waddr_i (prog_addr),
        .wdata_i (prog_data),
        .rd_i    (rd_c),
        .raddr_i (fetch_addr),
        .rdata_o (fetch_data)
    );

    assign fetch_ok = fetch_ok_q;
    assign cpu_rst  = cpu_rst_q;
    assign dl_busy  = busy_q;
    assign dl_done  = done_q;
    assign dl_cnt   = cnt_q;
    assign dl_sum   = sum_q;

endmodule
